// File: rtl/fft4_stream.sv
// fft4_stream: streaming 4-point radix-2 FFT with valid/ready handshakes on both sides.
// Four samples are collected per frame, transformed in one cycle and drained as X0..X3.
module fft4_stream #(
   parameter int DW = 16,
   localparam int OW = DW + 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
   input  logic          in_scale,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_re,
   output logic [OW-1:0] out_im,
   output logic [1:0]    out_idx,
   output logic          out_last
);

   logic [1:0]           in_cnt;
   logic                 full_in;
   logic                 frame_scale;
   logic [DW-1:0]        x_re [4];
   logic [DW-1:0]        x_im [4];
   logic [OW-1:0]        bank_re [4];
   logic [OW-1:0]        bank_im [4];
   logic                 accept;
   logic                 transfer;

   logic signed [OW-1:0] xr [4];
   logic signed [OW-1:0] xi [4];
   logic signed [OW-1:0] fr [4];
   logic signed [OW-1:0] fi [4];
   logic [OW-1:0]        yr [4];
   logic [OW-1:0]        yi [4];
   logic signed [OW-1:0] a0r, a0i, a1r, a1i, b0r, b0i, dr, di;

   // The output bank is free when idle or when its last bin leaves this cycle.
   assign transfer  = full_in && (!out_valid || (out_ready && out_last));
   assign in_ready  = !full_in || transfer;
   assign accept    = in_valid && in_ready;
   assign out_last  = out_valid && (out_idx == 2'd3);
   assign out_re    = bank_re[out_idx];
   assign out_im    = bank_im[out_idx];

   for (genvar n = 0; n < 4; n++) begin : g_ext
      assign xr[n] = {{2{x_re[n][DW-1]}}, x_re[n]};
      assign xi[n] = {{2{x_im[n][DW-1]}}, x_im[n]};
      assign yr[n] = frame_scale ? (fr[n] >>> 2) : fr[n];
      assign yi[n] = frame_scale ? (fi[n] >>> 2) : fi[n];
   end

   // Two butterfly stages; the -j twiddle on the odd difference is a swap plus negation.
   always_comb begin
      a0r = xr[0] + xr[2];
      a0i = xi[0] + xi[2];
      a1r = xr[0] - xr[2];
      a1i = xi[0] - xi[2];
      b0r = xr[1] + xr[3];
      b0i = xi[1] + xi[3];
      dr  = xr[1] - xr[3];
      di  = xi[1] - xi[3];
      fr[0] = a0r + b0r;
      fi[0] = a0i + b0i;
      fr[2] = a0r - b0r;
      fi[2] = a0i - b0i;
      fr[1] = a1r + di;
      fi[1] = a1i - dr;
      fr[3] = a1r - di;
      fi[3] = a1i + dr;
   end

   // Input collector; a slot-0 write on a transfer edge lands after the old frame was consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_cnt      <= 2'd0;
         full_in     <= 1'b0;
         frame_scale <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            x_re[k] <= '0;
            x_im[k] <= '0;
         end
      end else begin
         if (accept) begin
            x_re[in_cnt] <= in_re;
            x_im[in_cnt] <= in_im;
            in_cnt       <= in_cnt + 2'd1;
            if (in_cnt == 2'd0) begin
               frame_scale <= in_scale;
            end
         end
         if (accept && (in_cnt == 2'd3)) begin
            full_in <= 1'b1;
         end else if (transfer) begin
            full_in <= 1'b0;
         end
      end
   end

   // Output bank and drain sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_idx   <= 2'd0;
         for (int k = 0; k < 4; k++) begin
            bank_re[k] <= '0;
            bank_im[k] <= '0;
         end
      end else if (transfer) begin
         out_valid <= 1'b1;
         out_idx   <= 2'd0;
         for (int k = 0; k < 4; k++) begin
            bank_re[k] <= yr[k];
            bank_im[k] <= yi[k];
         end
      end else if (out_valid && out_ready) begin
         out_idx <= out_idx + 2'd1;
         if (out_idx == 2'd3) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft4_stream.sv
// tb_fft4_stream: randomized and directed frames for fft4_stream, checked against a direct
// 4-point DFT model with a scoreboard of expected bins.
module tb_fft4_stream;

   localparam int DW   = 16;
   localparam int OW   = DW + 2;
   localparam int SMIN = -(1 << (DW - 1));
   localparam int SMAX = (1 << (DW - 1)) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_re;
   logic [DW-1:0] in_im;
   logic          in_scale;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_re;
   logic [OW-1:0] out_im;
   logic [1:0]    out_idx;
   logic          out_last;

   fft4_stream #(.DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_im     (in_im),
      .in_scale  (in_scale),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   typedef struct { int re; int im; bit scale; } samp_t;
   typedef struct { int re; int im; int idx; } bin_t;

   samp_t inQ[$];
   bin_t  expQ[$];
   samp_t cur;
   bit    haveDrive = 1'b0;
   int    frameRe [4];
   int    frameIm [4];
   int    frameCnt = 0;
   bit    frameScale = 1'b0;
   int    errors = 0;
   int    checks = 0;
   int    validPct = 100;
   int    readyPct = 100;
   int    stallCycles = 0;
   bit    b2bWatch = 1'b0;
   bit    seenOut = 1'b0;
   int    readyDrops = 0;
   int    outGaps = 0;
   bit    bpWatch = 1'b0;
   bit    sawReadyLow = 1'b0;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Direct DFT: X[k] = sum x[n] * (-j)^(n*k), then optional floor divide by 4.
   task automatic refFft();
      int sr, si, m;
      for (int k = 0; k < 4; k++) begin
         sr = 0;
         si = 0;
         for (int n = 0; n < 4; n++) begin
            m = (n * k) % 4;
            case (m)
               0: begin sr += frameRe[n]; si += frameIm[n]; end
               1: begin sr += frameIm[n]; si -= frameRe[n]; end
               2: begin sr -= frameRe[n]; si -= frameIm[n]; end
               default: begin sr -= frameIm[n]; si += frameRe[n]; end
            endcase
         end
         if (frameScale) begin
            sr = sr >>> 2;
            si = si >>> 2;
         end
         expQ.push_back('{re: sr, im: si, idx: k});
      end
   endtask

   // Non-first samples carry the opposite scale so only the slot-0 value may matter.
   task automatic pushFrame(input int r[4], input int i[4], input bit sc);
      for (int n = 0; n < 4; n++) begin
         inQ.push_back('{re: r[n], im: i[n], scale: (n == 0) ? sc : !sc});
      end
   endtask

   function automatic int randSample();
      case ($urandom_range(7))
         0:       return SMIN;
         1:       return SMAX;
         default: return int'($urandom_range(SMAX - SMIN)) + SMIN;
      endcase
   endfunction

   task automatic pushRandomFrame();
      int r[4], i[4];
      for (int n = 0; n < 4; n++) begin
         r[n] = randSample();
         i[n] = randSample();
      end
      pushFrame(r, i, 1'($urandom));
   endtask

   // One cycle: observe at the falling edge, then drive just after the rising edge.
   task automatic applyStimulus();
      bin_t e;
      @(negedge clk);
      if (b2bWatch) begin
         if (haveDrive && !in_ready) readyDrops++;
         if (seenOut && !out_valid && expQ.size() > 0) outGaps++;
         if (out_valid) seenOut = 1'b1;
      end
      if (bpWatch && haveDrive && !in_ready) sawReadyLow = 1'b1;
      if (out_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("spurious_out_valid", 1, 0);
         end else begin
            e = expQ[0];
            checkOutput($sformatf("bin%0d_re", e.idx), $signed(out_re), e.re);
            checkOutput($sformatf("bin%0d_im", e.idx), $signed(out_im), e.im);
            checkOutput("out_idx", int'(out_idx), e.idx);
            checkOutput("out_last", int'(out_last), (e.idx == 3) ? 1 : 0);
            if (out_ready) expQ.delete(0);
         end
      end
      if (in_valid && in_ready) begin
         if (frameCnt == 0) frameScale = cur.scale;
         frameRe[frameCnt] = cur.re;
         frameIm[frameCnt] = cur.im;
         frameCnt++;
         haveDrive = 1'b0;
         if (frameCnt == 4) begin
            refFft();
            frameCnt = 0;
         end
      end
      @(posedge clk);
      #1;
      if (!haveDrive && inQ.size() > 0 && $urandom_range(99) < validPct) begin
         cur = inQ.pop_front();
         haveDrive = 1'b1;
      end
      in_valid = haveDrive;
      in_re    = haveDrive ? DW'(cur.re) : DW'($urandom);
      in_im    = haveDrive ? DW'(cur.im) : DW'($urandom);
      in_scale = haveDrive ? cur.scale : 1'($urandom);
      if (stallCycles > 0) begin
         out_ready = 1'b0;
         stallCycles--;
      end else begin
         out_ready = ($urandom_range(99) < readyPct);
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while ((inQ.size() > 0 || haveDrive || frameCnt != 0 || expQ.size() > 0) && n < budget) begin
         applyStimulus();
         n++;
      end
      checkOutput({tag, "_pending"}, inQ.size() + expQ.size() + frameCnt + int'(haveDrive), 0);
      applyStimulus();
      checkOutput({tag, "_idle"}, int'(out_valid), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int r[4], i[4];
      int n;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_re     = '0;
      in_im     = '0;
      in_scale  = 1'b0;
      out_ready = 1'b0;
      #12;
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_out_re", int'(out_re), 0);
      checkOutput("rst_out_im", int'(out_im), 0);
      checkOutput("rst_out_idx", int'(out_idx), 0);
      checkOutput("rst_out_last", int'(out_last), 0);
      checkOutput("rst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] directed frames");
      r = '{1, 0, 0, 0};  i = '{0, 0, 0, 0};  pushFrame(r, i, 1'b0);
      r = '{0, 1, 0, 0};  pushFrame(r, i, 1'b0);
      r = '{SMIN, SMIN, SMIN, SMIN};
      i = '{SMAX, SMAX, SMAX, SMAX};
      pushFrame(r, i, 1'b0);
      pushFrame(r, i, 1'b1);
      drain("directed", 200);

      $display("[TB] back-to-back frames");
      b2bWatch = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 4; k++) begin
            r[k] = randSample();
            i[k] = randSample();
         end
         pushFrame(r, i, 1'(f % 2));
      end
      drain("b2b", 100);
      b2bWatch = 1'b0;
      checkOutput("b2b_in_ready_drops", readyDrops, 0);
      checkOutput("b2b_out_gaps", outGaps, 0);
      checkOutput("b2b_saw_output", int'(seenOut), 1);

      $display("[TB] backpressure");
      for (int f = 0; f < 3; f++) pushRandomFrame();
      n = 0;
      while (!(out_valid && out_idx == 2'd1) && n < 50) begin
         applyStimulus();
         n++;
      end
      checkOutput("bp_reached_mid_frame", int'(out_valid && out_idx == 2'd1), 1);
      stallCycles = 10;
      bpWatch = 1'b1;
      for (int c = 0; c < 11; c++) applyStimulus();
      bpWatch = 1'b0;
      checkOutput("bp_in_ready_fell", int'(sawReadyLow), 1);
      drain("bp", 200);

      $display("[TB] randomized handshakes");
      validPct = 70;
      readyPct = 60;
      for (int f = 0; f < 20; f++) pushRandomFrame();
      drain("random", 2000);

      $display("[TB] reset mid-operation");
      validPct = 100;
      readyPct = 100;
      pushRandomFrame();
      inQ.push_back('{re: randSample(), im: randSample(), scale: 1'b0});
      inQ.push_back('{re: randSample(), im: randSample(), scale: 1'b1});
      n = 0;
      while (!(frameCnt == 2 && out_valid) && n < 50) begin
         applyStimulus();
         n++;
      end
      checkOutput("rst2_setup_reached", int'(frameCnt == 2 && out_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst2_out_valid", int'(out_valid), 0);
      checkOutput("rst2_out_re", int'(out_re), 0);
      checkOutput("rst2_out_im", int'(out_im), 0);
      checkOutput("rst2_out_idx", int'(out_idx), 0);
      checkOutput("rst2_out_last", int'(out_last), 0);
      checkOutput("rst2_in_ready", int'(in_ready), 1);
      expQ.delete();
      inQ.delete();
      haveDrive = 1'b0;
      frameCnt  = 0;
      in_valid  = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      r = '{3, -4, 100, SMAX};
      i = '{-9, SMIN, 7, 0};
      pushFrame(r, i, 1'b1);
      drain("post_reset", 100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
